lfsr_prbs_gen: RTL

LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

---
 rtl/lfsr_prbs_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lfsr_prbs_gen.sv
// ============================================================================
//  Module   : lfsr_prbs_gen
//  Purpose  : Fibonacci XNOR LFSR PRBS generator with ones/zeros tallies,
//             wrap detection and sequence-period measurement.
//  Options  : `define LFSR_LOCKUP_GUARD_EN to build the all-ones lock-up
//             guard (seed substitution plus one-cycle lockup pulse).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_prbs_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sh_en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] Q_out,
    output logic             bit_out,
    output logic [CNT_W-1:0] ones,
    output logic [CNT_W-1:0] zeros,
    output logic             max_tick,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lockup
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_start;
    logic [CNT_W-1:0] r_ones;
    logic [CNT_W-1:0] r_zeros;
    logic [WIDTH-1:0] r_steps;
    logic [WIDTH-1:0] r_period;
    logic             r_pvalid;
    logic             r_tick;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // XNOR feedback keeps the all-zeros state legal; all-ones is the lock-up state.
    assign w_fb   = ~^(r_q & TAPS);
    assign w_next = {r_q[WIDTH-2:0], w_fb};
    assign w_wrap = (w_next == r_start);

`ifdef LFSR_LOCKUP_GUARD_EN
    logic r_lock;
    logic w_seed_bad;
    logic w_stuck;

    assign w_seed_bad = &seed_in;
    assign w_stuck    = &r_q;
`endif

    // Main state: LFSR, reference seed, tallies, period measurement and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q      <= SEED;
            r_start  <= SEED;
            r_ones   <= '0;
            r_zeros  <= '0;
            r_steps  <= '0;
            r_period <= '0;
            r_pvalid <= 1'b0;
            r_tick   <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
            r_lock   <= 1'b0;
`endif
        end else begin
            // Pulses default low; only a wrap or a recovery raises them.
            r_tick <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
            r_lock <= 1'b0;
`endif
            if (load) begin
`ifdef LFSR_LOCKUP_GUARD_EN
                if (w_seed_bad) begin
                    r_q     <= SEED;
                    r_start <= SEED;
                    r_lock  <= 1'b1;
                end else
`endif
                begin
                    r_q     <= seed_in;
                    r_start <= seed_in;
                end
                r_ones   <= '0;
                r_zeros  <= '0;
                r_steps  <= '0;
                r_pvalid <= 1'b0;
            end else if (sh_en) begin
`ifdef LFSR_LOCKUP_GUARD_EN
                if (w_stuck) begin
                    // Recovery restarts the measurement from the fallback seed.
                    r_q     <= SEED;
                    r_start <= SEED;
                    r_steps <= '0;
                    r_lock  <= 1'b1;
                end else
`endif
                begin
                    r_q <= w_next;
                    // Tally the bit being shifted out, saturating at full scale.
                    if (r_q[WIDTH-1]) begin
                        if (r_ones != C_CNT_MAX) r_ones <= r_ones + 1'b1;
                    end else begin
                        if (r_zeros != C_CNT_MAX) r_zeros <= r_zeros + 1'b1;
                    end
                    if (w_wrap) begin
                        r_period <= r_steps + 1'b1;
                        r_pvalid <= 1'b1;
                        r_steps  <= '0;
                        r_tick   <= 1'b1;
                    end else begin
                        r_steps  <= r_steps + 1'b1;
                    end
                end
            end
        end
    end

    assign Q_out        = r_q;
    assign bit_out      = r_q[WIDTH-1];
    assign ones         = r_ones;
    assign zeros        = r_zeros;
    assign max_tick     = r_tick;
    assign period       = r_period;
    assign period_valid = r_pvalid;
`ifdef LFSR_LOCKUP_GUARD_EN
    assign lockup       = r_lock;
`else
    assign lockup       = 1'b0;
`endif

endmodule

`default_nettype wire
